// File: rtl/riscv_aes_ex_unit_if.sv
// riscv_aes_ex_unit_if: EX-stage issue/result bundle between the decoder and the AES unit
interface riscv_aes_ex_unit_if;
  logic        valid_i;
  logic [2:0]  aes_op_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        ready_o;
  logic [31:0] result_o;
  logic        err_o;
  logic        busy_o;
  modport master (output valid_i, aes_op_i, operand_a_i, operand_b_i,
                  input ready_o, result_o, err_o, busy_o);
  modport slave (input valid_i, aes_op_i, operand_a_i, operand_b_i,
                 output ready_o, result_o, err_o, busy_o);
endinterface

// File: rtl/riscv_aes_ex_unit.sv
// riscv_aes_ex_unit: multi-cycle AES-128 encryptor for the EX stage, SubBytes spread over
// 16/SBOX_LANES cycles per round, with a non-blocking START and stalling reads.
module riscv_aes_ex_unit #(
  parameter int SBOX_LANES = 16,
  parameter int NUM_ROUNDS = 10
) (
  input logic clk,
  input logic rst_n,
  riscv_aes_ex_unit_if.slave bus
);
  localparam int C = 16 / SBOX_LANES;
  localparam int CW = C > 1 ? $clog2(C) : 1;
  localparam logic [2:0] OP_KEYW = 3'd0, OP_DATAW = 3'd1, OP_START = 3'd2, OP_RDW = 3'd3,
                         OP_STATUS = 3'd4, OP_CLEAR = 3'd5;
  typedef enum logic {IDLE, RUN} state_e;
  if (!(SBOX_LANES == 4 || SBOX_LANES == 8 || SBOX_LANES == 16) || NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_param_err
    $error("riscv_aes_ex_unit: SBOX_LANES must be 4/8/16 and NUM_ROUNDS 1..10");
  end
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, m;
    p = 8'h00;
    m = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ m : p;
      m = xt(m);
    end
    return p;
  endfunction
  // multiplicative inverse as x^254, then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      r = (i != 0) ? gmul(r, x) : r;
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 2; i <= 10; i++) r = (i <= int'(rnd)) ? xt(r) : r;
    return r;
  endfunction
  function automatic logic [7:0] byt(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction
  state_e st_q, st_d;
  logic [127:0] key_q, key_d, state_q, state_d, rk_q, rk_d;
  logic [127:0] sub_st, sr_st, mc_st, nk, rnd_st;
  logic [3:0] round_q, round_d;
  logic [CW-1:0] sub_q, sub_d;
  logic done_q, done_d;
  logic [31:0] t;
  logic run, acc, last_sub, last;
  logic [2:0] op;
  int widx;
  logic unused_b;
  assign unused_b = ^bus.operand_b_i[31:2];
  assign op = bus.aes_op_i;
  assign widx = int'(bus.operand_b_i[1:0]);
  assign run = st_q == RUN;
  assign last_sub = sub_q == CW'(C - 1);
  assign last = round_q == 4'(NUM_ROUNDS);
  assign bus.busy_o = run;
  assign bus.ready_o = !(bus.valid_i && run && !op[2]);
  assign acc = bus.valid_i && bus.ready_o;
  assign bus.err_o = acc && op[2] && op[1];
  assign bus.result_o = !acc ? 32'h0 :
                        op == OP_RDW ? state_q[127-32*widx -: 32] :
                        op == OP_STATUS ? {30'b0, done_q, run} : 32'h0;
  always_comb begin
    sub_st = state_q;
    for (int j = 0; j < SBOX_LANES; j++)
      sub_st[127-8*(int'(sub_q)*SBOX_LANES+j) -: 8] = sbox(byt(state_q, int'(sub_q)*SBOX_LANES + j));
    sr_st = '0;
    mc_st = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr_st[127-8*(4*c+r) -: 8] = byt(sub_st, 4*((c+r)%4) + r);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        mc_st[127-8*(4*c+r) -: 8] = xt(byt(sr_st, 4*c+r)) ^ xt(byt(sr_st, 4*c+(r+1)%4)) ^
                                    byt(sr_st, 4*c+(r+1)%4) ^ byt(sr_st, 4*c+(r+2)%4) ^ byt(sr_st, 4*c+(r+3)%4);
    t = {sbox(rk_q[23:16]) ^ rcon(round_q), sbox(rk_q[15:8]), sbox(rk_q[7:0]), sbox(rk_q[31:24])};
    nk[127:96] = rk_q[127:96] ^ t;
    nk[95:64] = rk_q[95:64] ^ nk[127:96];
    nk[63:32] = rk_q[63:32] ^ nk[95:64];
    nk[31:0] = rk_q[31:0] ^ nk[63:32];
    rnd_st = (last ? sr_st : mc_st) ^ nk;
  end
  always_comb begin
    st_d = st_q;
    key_d = key_q;
    state_d = state_q;
    rk_d = rk_q;
    round_d = round_q;
    sub_d = sub_q;
    done_d = done_q;
    if (run) begin
      sub_d = last_sub ? '0 : sub_q + 1'b1;
      state_d = last_sub ? rnd_st : sub_st;
      rk_d = last_sub ? nk : rk_q;
      round_d = last_sub ? round_q + 4'd1 : round_q;
      st_d = (last_sub && last) ? IDLE : RUN;
      done_d = done_q || (last_sub && last);
    end
    if (acc) begin
      case (op)
        OP_KEYW: key_d[127-32*widx -: 32] = bus.operand_a_i;
        OP_DATAW: state_d[127-32*widx -: 32] = bus.operand_a_i;
        OP_START: begin
          state_d = state_q ^ key_q;
          rk_d = key_q;
          round_d = 4'd1;
          sub_d = '0;
          done_d = 1'b0;
          st_d = RUN;
        end
        OP_CLEAR: begin
          key_d = '0;
          state_d = '0;
          rk_d = '0;
          round_d = '0;
          sub_d = '0;
          done_d = 1'b0;
          st_d = IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      key_q <= '0;
      state_q <= '0;
      rk_q <= '0;
      round_q <= '0;
      sub_q <= '0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      key_q <= key_d;
      state_q <= state_d;
      rk_q <= rk_d;
      round_q <= round_d;
      sub_q <= sub_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_riscv_aes_ex_unit.sv
// tb_riscv_aes_ex_unit: drives four unit configurations (16/4/8 lanes, and a 1-round build)
// against a byte-array AES reference model.
module tb_riscv_aes_ex_unit;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int LANES [4] = '{16, 4, 8, 16};
  localparam int NRS [4] = '{10, 10, 10, 1};
  logic clk = 1'b0;
  logic rst_n;
  logic vld [4];
  logic [2:0] opv [4];
  logic [31:0] av [4], bv [4];
  logic rdy [4], errv [4], bsy [4];
  logic [31:0] res [4];
  logic last_err;
  logic [7:0] sbox_t [256];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    riscv_aes_ex_unit_if bus ();
    assign bus.valid_i = vld[g];
    assign bus.aes_op_i = opv[g];
    assign bus.operand_a_i = av[g];
    assign bus.operand_b_i = bv[g];
    assign rdy[g] = bus.ready_o;
    assign res[g] = bus.result_o;
    assign errv[g] = bus.err_o;
    assign bsy[g] = bus.busy_o;
    riscv_aes_ex_unit #(.SBOX_LANES(LANES[g]), .NUM_ROUNDS(NRS[g])) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction
  function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int r = 1; r <= nr; r++) begin
      k[0] ^= sbox_t[k[13]] ^ rc;
      k[1] ^= sbox_t[k[14]];
      k[2] ^= sbox_t[k[15]];
      k[3] ^= sbox_t[k[12]];
      for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
      rc = gm(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
      if (r < nr)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          s[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end
      for (int i = 0; i < 16; i++) s[i] ^= k[i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction
  task automatic issue(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int st);
    vld[d] = 1'b1;
    opv[d] = op;
    av[d] = a;
    bv[d] = b;
    st = 0;
    #1;
    while (!rdy[d] && st < 100) begin
      @(negedge clk);
      #1;
      st++;
    end
    check($sformatf("accepted d%0d op%0d", d, op), rdy[d], 1);
    r = res[d];
    last_err = errv[d];
    @(negedge clk);
    vld[d] = 1'b0;
  endtask
  task automatic load(input int d, input logic [127:0] k, input logic [127:0] p);
    logic [31:0] r;
    int st;
    for (int w = 0; w < 4; w++) issue(d, 3'd0, k[127-32*w -: 32], w, r, st);
    for (int w = 0; w < 4; w++) issue(d, 3'd1, p[127-32*w -: 32], w, r, st);
  endtask
  task automatic read_ct(input int d, output logic [127:0] ct, output int st0);
    logic [31:0] r;
    int st;
    for (int w = 0; w < 4; w++) begin
      issue(d, 3'd3, 32'h0, w, r, st);
      ct[127-32*w -: 32] = r;
      if (w == 0) st0 = st;
    end
  endtask
  initial begin
    logic [7:0] inv;
    logic [31:0] r, x;
    logic [127:0] ct, exp, k, p;
    int st, d;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 0; opv[i] = 0; av[i] = 0; bv[i] = 0;
    end
    rst_n = 1'b0;
    for (int v = 0; v < 256; v++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        sbox_t[v][i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 1);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset ready d%0d", i), rdy[i], 1);
      check($sformatf("reset busy d%0d", i), bsy[i], 0);
      check($sformatf("reset err d%0d", i), errv[i], 0);
      check($sformatf("reset result d%0d", i), res[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // FIPS-197 vector on every configuration
    for (int g = 0; g < 4; g++) begin
      load(g, FK, FP);
      issue(g, 3'd2, 0, 0, r, st);
      if (NRS[g] == 10) begin
        issue(g, 3'd4, 0, 0, r, st);
        check($sformatf("mid-run status d%0d", g), r, 1);
        check($sformatf("mid-run status stall d%0d", g), st, 0);
      end
      read_ct(g, ct, st);
      check($sformatf("rdw stall d%0d", g), st, NRS[g] * 16 / LANES[g] - (NRS[g] == 10 ? 1 : 0));
      check($sformatf("ciphertext d%0d", g), ct, ref_enc(FK, FP, NRS[g]));
      if (NRS[g] == 10) check($sformatf("fips ct d%0d", g), ct, FC);
      issue(g, 3'd4, 0, 0, r, st);
      check($sformatf("done status d%0d", g), r, 2);
    end
    // non-blocking issue, then a DATAW that must wait for the run
    exp = ref_enc(FK, FC, 10);
    issue(0, 3'd2, 0, 0, r, st);
    for (int i = 0; i < 5; i++) begin
      issue(0, 3'd4, 0, 0, r, st);
      check("poll status", r, 1);
      check("poll stall", st, 0);
    end
    x = $urandom;
    issue(0, 3'd1, x, 2, r, st);
    check("dataw stall", st, 5);
    exp[63:32] = x;
    issue(0, 3'd4, 0, 0, r, st);
    check("status after dataw", r, 2);
    read_ct(0, ct, st);
    check("ct with dataw", ct, exp);
    // abort with CLEAR at run cycle 3
    issue(0, 3'd2, 0, 0, r, st);
    issue(0, 3'd4, 0, 0, r, st);
    issue(0, 3'd4, 0, 0, r, st);
    issue(0, 3'd5, 0, 0, r, st);
    check("clear stall", st, 0);
    #1;
    check("busy after clear", bsy[0], 0);
    read_ct(0, ct, st);
    check("state after clear", ct, 0);
    check("rdw stall after clear", st, 0);
    issue(0, 3'd4, 0, 0, r, st);
    check("status after clear", r, 0);
    issue(0, 3'd2, 0, 0, r, st);
    read_ct(0, ct, st);
    check("ct with cleared key", ct, ref_enc(0, 0, 10));
    // undefined ops, idle and mid-run
    for (int o = 6; o < 8; o++) begin
      issue(0, 3'(o), $urandom, $urandom, r, st);
      check($sformatf("undef%0d result", o), r, 0);
      check($sformatf("undef%0d err", o), last_err, 1);
      check($sformatf("undef%0d stall", o), st, 0);
    end
    #1;
    check("err idle", errv[0], 0);
    read_ct(0, ct, st);
    check("state after undef", ct, ref_enc(0, 0, 10));
    issue(0, 3'd2, 0, 0, r, st);
    issue(0, 3'd6, 0, 0, r, st);
    check("undef in run err", last_err, 1);
    check("undef in run stall", st, 0);
    exp = ref_enc(0, ct, 10);
    read_ct(0, ct, st);
    check("ct after undef in run", ct, exp);
    // single-round build, zero key and data
    load(3, 0, 0);
    issue(3, 3'd2, 0, 0, r, st);
    read_ct(3, ct, st);
    check("one-round stall", st, 1);
    check("one-round zero ct", ct, ref_enc(0, 0, 1));
    // random key/plaintext on random configurations
    for (int it = 0; it < 8; it++) begin
      d = $urandom_range(0, 3);
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      load(d, k, p);
      issue(d, 3'd2, 0, 0, r, st);
      read_ct(d, ct, st);
      check($sformatf("rand%0d stall d%0d", it, d), st, NRS[d] * 16 / LANES[d]);
      check($sformatf("rand%0d ct d%0d", it, d), ct, ref_enc(k, p, NRS[d]));
    end
    // asynchronous reset in the middle of a run
    issue(0, 3'd2, 0, 0, r, st);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset busy", bsy[0], 0);
    check("async reset ready", rdy[0], 1);
    check("async reset result", res[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    read_ct(0, ct, st);
    check("state after reset", ct, 0);
    issue(0, 3'd4, 0, 0, r, st);
    check("status after reset", r, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
